pipe_stage_ctrl: RTL and testbench

//  Valid/ready sequencer for a linear chain of NUM_STAGES data_dff pipeline registers.

---
 rtl/pipe_stage_ctrl_pkg.sv | 13 +
 rtl/pipe_stage_ctrl_if.sv | 30 +++
 rtl/pipe_stage_cell.sv | 27 ++
 rtl/pipe_stage_ctrl.sv | 67 ++++++
 tb/tb_pipe_stage_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared constants for the pipeline stage controller: data width, default depth
// and the occupancy-width helper.
package pipe_stage_ctrl_pkg;

  localparam int XLEN               = 32;
  localparam int DEFAULT_NUM_STAGES = 4;

  // Bits needed to count 0..n valid stages.
  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Handshake, flush and per-stage status bundle of the pipeline stage controller.
// Handshakes: a word moves only in a cycle where valid and ready are both high;
// valid must not depend on ready, and an offered word is held until it is taken.
interface pipe_stage_ctrl_if
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int OCC_W      = occ_width(NUM_STAGES)
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_vld;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, out_ready, flush,
    input  in_ready, out_valid, stage_en, stage_vld, occupancy
  );

  modport slave (
    input  in_valid, out_ready, flush,
    output in_ready, out_valid, stage_en, stage_vld, occupancy
  );

endinterface

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: its valid flop plus the local ready and register-enable terms.
module pipe_stage_cell (
  input  logic i_clk,
  input  logic i_rst,
  input  logic src_valid,
  input  logic rdy_next,
  input  logic flush,
  output logic vld,
  output logic rdy,
  output logic en,
  output logic vld_next
);

  // A stage can take a word if it is empty or its own word leaves this cycle.
  assign rdy      = !vld | rdy_next;
  assign en       = src_valid & rdy & !flush & !i_rst;
  assign vld_next = flush ? 1'b0 : (en | (vld & !rdy_next));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld <= 1'b0;
    end else begin
      vld <= vld_next;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Valid/ready sequencer for a chain of pipeline registers: one enable per stage,
// bubble collapse, back-pressure and flush. Datapath registers live outside.
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int OCC_W      = occ_width(NUM_STAGES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pipe_stage_ctrl_if.slave  bus
);

  logic [NUM_STAGES:0]   rdy_chain;
  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] vld_next;
  logic [NUM_STAGES-1:0] en;
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_next;

  // Ready ripples from the consumer back to the producer in the same cycle.
  assign rdy_chain[NUM_STAGES] = bus.out_ready;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic src_valid;
    if (k == 0) begin : g_head
      assign src_valid = bus.in_valid;
    end else begin : g_body
      assign src_valid = vld[k-1];
    end

    pipe_stage_cell u_cell (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .src_valid (src_valid),
      .rdy_next  (rdy_chain[k+1]),
      .flush     (bus.flush),
      .vld       (vld[k]),
      .rdy       (rdy_chain[k]),
      .en        (en[k]),
      .vld_next  (vld_next[k])
    );
  end

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occ_next = occ_next + OCC_W'(vld_next[k]);
    end
  end

  // Occupancy is registered from the same next-state as the valid flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_next;
    end
  end

  assign bus.in_ready  = rdy_chain[0] & !bus.flush & !i_rst;
  assign bus.out_valid = vld[NUM_STAGES-1];
  assign bus.stage_en  = en;
  assign bus.stage_vld = vld;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: a data register chain driven by stage_en, an item-list
// reference model with scoreboard, and one task per scenario.
module tb_pipe_stage_ctrl;
  import pipe_stage_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int OW = occ_width(N);
  localparam int W  = XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_ctrl_if #(.NUM_STAGES(N)) bus ();

  pipe_stage_ctrl #(.NUM_STAGES(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [W-1:0] din;
  logic [W-1:0] dchain [N];
  int n_cmp = 0;
  int n_err = 0;

  // External datapath: each stage register loads from its predecessor when enabled.
  always @(posedge clk) begin
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.stage_en[k]) dchain[k] <= (k == 0) ? din : dchain[(k == 0) ? 0 : k - 1];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // The pipe is a FIFO list of words, each at a stage position; every cycle a word
  // steps forward by one unless the word ahead of it stays put right in front.
  int           pos_q[$];
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin : scoreboard
    logic [N-1:0] e_vld, e_en;
    logic         e_rdy, e_ov;
    int           np_q[$];
    logic [W-1:0] nd_q[$];
    int           maxpos, np;
    if (rst) begin
      pos_q.delete(); exp_q.delete();
      n_cmp++;
      if ({bus.stage_vld, bus.stage_en, bus.occupancy, bus.in_ready, bus.out_valid} !== '0) begin
        n_err++;
        $display("FAIL sb_reset: vld=%b en=%b occ=%0d in_ready=%b out_valid=%b, want all zero",
                 bus.stage_vld, bus.stage_en, bus.occupancy, bus.in_ready, bus.out_valid);
      end
    end else begin
      e_vld = '0;
      foreach (pos_q[i]) e_vld[pos_q[i]] = 1'b1;
      e_ov  = (pos_q.size() > 0) && (pos_q[0] == N - 1);
      e_rdy = !bus.flush && ((pos_q.size() < N) || bus.out_ready);
      e_en  = '0;
      np_q.delete(); nd_q.delete();
      if (!bus.flush) begin
        maxpos = bus.out_ready ? N : N - 1;
        foreach (pos_q[i]) begin
          np = (pos_q[i] + 1 < maxpos) ? pos_q[i] + 1 : maxpos;
          if (np != pos_q[i] && np < N) e_en[np] = 1'b1;
          if (np == N) begin
            n_cmp++;
            if (dchain[N-1] !== exp_q[i]) begin
              n_err++;
              $display("FAIL sb_data: out word %h, want %h", dchain[N-1], exp_q[i]);
            end
          end else begin
            np_q.push_back(np);
            nd_q.push_back(exp_q[i]);
          end
          maxpos = np - 1;
        end
        if (bus.in_valid && e_rdy) begin
          e_en[0] = 1'b1;
          np_q.push_back(0);
          nd_q.push_back(din);
        end
      end
      n_cmp++;
      if (bus.stage_vld !== e_vld) begin
        n_err++; $display("FAIL sb_vld: got %b want %b", bus.stage_vld, e_vld);
      end
      n_cmp++;
      if (bus.occupancy !== OW'(pos_q.size())) begin
        n_err++; $display("FAIL sb_occ: got %0d want %0d", bus.occupancy, pos_q.size());
      end
      n_cmp++;
      if (bus.stage_en !== e_en) begin
        n_err++; $display("FAIL sb_en: got %b want %b", bus.stage_en, e_en);
      end
      n_cmp++;
      if (bus.in_ready !== e_rdy) begin
        n_err++; $display("FAIL sb_in_ready: got %b want %b", bus.in_ready, e_rdy);
      end
      n_cmp++;
      if (bus.out_valid !== e_ov) begin
        n_err++; $display("FAIL sb_out_valid: got %b want %b", bus.out_valid, e_ov);
      end
      pos_q = np_q;
      exp_q = nd_q;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = v;
    din           = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic drain();
    int c;
    drive(1'b0, '0, 1'b1, 1'b0);
    c = 0;
    @(negedge clk);
    while (bus.occupancy != 0 && c < 20) begin
      step();
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (bus.occupancy !== '0) begin
      n_err++; $display("FAIL drain_timeout: occupancy %0d after %0d cycles, want 0", bus.occupancy, c);
    end
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({bus.stage_vld, bus.occupancy, bus.out_valid, bus.stage_en, bus.in_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_state: vld=%b occ=%0d ov=%b en=%b ir=%b, want all zero",
               bus.stage_vld, bus.occupancy, bus.out_valid, bus.stage_en, bus.in_ready);
    end
    step();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_fill_drain();
    int cyc, acc_cyc, out_cyc, next_w;
    logic acc;
    logic [W-1:0] got[$];
    cyc = 0; acc_cyc = -1; out_cyc = -1; next_w = 1;
    drive(1'b1, 1, 1'b1, 1'b0);
    while (got.size() < 8 && cyc < 40) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc && acc_cyc < 0) acc_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (out_cyc < 0) out_cyc = cyc;
        got.push_back(dchain[N-1]);
      end
      step();
      cyc++;
      if (acc) begin
        next_w++;
        if (next_w > 8) bus.in_valid = 1'b0;
        else din = next_w;
      end
    end
    n_cmp++;
    if (out_cyc - acc_cyc !== 4) begin
      n_err++; $display("FAIL fill_latency: got %0d cycles want 4", out_cyc - acc_cyc);
    end
    n_cmp++;
    if (got.size() !== 8) begin
      n_err++; $display("FAIL fill_count: got %0d words want 8", got.size());
    end
    foreach (got[i]) begin
      n_cmp++;
      if (got[i] !== W'(i + 1)) begin
        n_err++; $display("FAIL fill_order[%0d]: got %0d want %0d", i, got[i], i + 1);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int w, cyc;
    logic acc;
    logic [W-1:0] got[$];
    w = 1;
    drive(1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      n_cmp++;
      if (acc !== (i < 4)) begin
        n_err++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, acc, (i < 4));
      end
      if (i == 4) begin
        n_cmp++;
        if (bus.occupancy !== OW'(4)) begin
          n_err++; $display("FAIL bp_occ: got %0d want 4", bus.occupancy);
        end
      end
      step();
      if (acc) begin w++; din = w; end
    end
    bus.out_ready = 1'b1;
    cyc = 0;
    while (got.size() < 6 && cyc < 40) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) got.push_back(dchain[N-1]);
      step();
      cyc++;
      if (acc) begin
        w++;
        if (w > 6) bus.in_valid = 1'b0;
        else din = w;
      end
    end
    n_cmp++;
    if (got.size() !== 6) begin
      n_err++; $display("FAIL bp_count: got %0d words want 6", got.size());
    end
    foreach (got[i]) begin
      n_cmp++;
      if (got[i] !== W'(i + 1)) begin
        n_err++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i + 1);
      end
    end
    drain();
  endtask

  task automatic test_bubble();
    drive(1'b1, 32'hA, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.stage_vld !== 4'b0101) begin
      n_err++; $display("FAIL bubble_vld0: got %b want 0101", bus.stage_vld);
    end
    // Both words step one stage on, closing the gap ahead of each.
    n_cmp++;
    if (bus.stage_en !== 4'b1010) begin
      n_err++; $display("FAIL bubble_en: got %b want 1010", bus.stage_en);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.stage_vld !== 4'b1010 || bus.occupancy !== OW'(2)) begin
      n_err++; $display("FAIL bubble_vld1: got vld=%b occ=%0d want vld=1010 occ=2", bus.stage_vld, bus.occupancy);
    end
    step();
    drain();
  endtask

  task automatic test_full_accept_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(10 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'd14, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.stage_en !== 4'b1111 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_en: got en=%b ir=%b want en=1111 ir=1", bus.stage_en, bus.in_ready);
    end
    n_cmp++;
    if (dchain[N-1] !== 32'd10) begin
      n_err++; $display("FAIL full_out0: got %0d want 10", dchain[N-1]);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.occupancy !== OW'(4) || dchain[N-1] !== 32'd11) begin
      n_err++; $display("FAIL full_after: got occ=%0d out=%0d want occ=4 out=11", bus.occupancy, dchain[N-1]);
    end
    step();
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(20 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'd23, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.stage_en !== '0 || bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_cycle: got en=%b ir=%b want en=0000 ir=0", bus.stage_en, bus.in_ready);
    end
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.stage_vld !== '0 || bus.occupancy !== '0 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_after: got vld=%b occ=%0d ov=%b want 0/0/0", bus.stage_vld, bus.occupancy, bus.out_valid);
    end
    step();
  endtask

  task automatic test_async_reset();
    int cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(30 + i), 1'b1, 1'b0);
      step();
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.stage_vld, bus.occupancy, bus.out_valid, bus.stage_en, bus.in_ready} !== '0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b occ=%0d ov=%b en=%b ir=%b want all zero",
               bus.stage_vld, bus.occupancy, bus.out_valid, bus.stage_en, bus.in_ready);
    end
    @(negedge clk);
    step();
    rst = 1'b0;
    drive(1'b1, 32'd77, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_accept: in_ready %b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 20) begin
      step();
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc + 1 !== 4 || dchain[N-1] !== 32'd77) begin
      n_err++; $display("FAIL post_reset_latency: got %0d cycles word %0d want 4 cycles word 77", cyc + 1, dchain[N-1]);
    end
    step();
    drain();
  endtask

  task automatic test_random();
    logic acc;
    drive(($urandom_range(0, 9) < 7), $urandom(), ($urandom_range(0, 9) < 6), 1'b0);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      n_cmp++;
      if (bus.occupancy > OW'(N)) begin
        n_err++; $display("FAIL rand_occ_bound: got %0d want <= %0d", bus.occupancy, N);
      end
      step();
      if (acc || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        din          = $urandom();
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 31) == 0);
    end
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    din = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_bubble();
    test_full_accept_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
